// File: rtl/register_level_pkg.sv
// Shared types and helpers for the level-1 register storage block.
// Holds the sweep FSM states, the field merge and address sizing.
package register_level_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Widest entry the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_W = 1024;

    // Bits set in bit_mask take new_v, the rest keep old_v.
    function automatic logic [MERGE_W-1:0] field_merge(
        input logic [MERGE_W-1:0] old_v,
        input logic [MERGE_W-1:0] new_v,
        input logic [MERGE_W-1:0] bit_mask
    );
        return (old_v & ~bit_mask) | (new_v & bit_mask);
    endfunction

    // Smallest address width able to index depth entries.
    function automatic int min_addr_w(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/register_level1_array.sv
// 1W1R flop storage with per-field write mask.
// No reset: the top-level clear sweep zeroes the contents.
module register_level1_array
    import register_level_pkg::*;
#(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 16,
    parameter int DEPTH      = 10,
    parameter int ADDR_W     = 4
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [NUM_FIELDS-1:0]         wmask,
    input  logic [NUM_FIELDS*FIELD_W-1:0] wdata,
    input  logic [ADDR_W-1:0]             raddr,
    output logic [NUM_FIELDS*FIELD_W-1:0] rdata
);

    localparam int DATA_W = NUM_FIELDS * FIELD_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] bit_mask;

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_mask
        assign bit_mask[i*FIELD_W +: FIELD_W] = {FIELD_W{wmask[i]}};
    end

    // Merge the enabled fields into the addressed entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= DATA_W'(field_merge(MERGE_W'(mem[waddr]),
                                              MERGE_W'(wdata),
                                              MERGE_W'(bit_mask)));
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/register_level1.sv
// Level-1 register storage: masked writes, pipelined reads with bypass,
// range checking and a hardware clear sweep.
module register_level1
    import register_level_pkg::*;
#(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 16,
    parameter int DEPTH      = 10,
    parameter int ADDR_W     = 4,
    parameter int OUT_REG    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_req,
    output logic                          busy,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [NUM_FIELDS-1:0]         wr_mask,
    input  logic [NUM_FIELDS*FIELD_W-1:0] wr_data,
    output logic                          wr_err,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_valid,
    output logic [NUM_FIELDS*FIELD_W-1:0] rd_data,
    output logic                          rd_err
);

    localparam int DATA_W = NUM_FIELDS * FIELD_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    if (ADDR_W < min_addr_w(DEPTH)) begin : g_addr_chk
        $error("ADDR_W too small for DEPTH");
    end
    if (DEPTH < 2) begin : g_depth_chk
        $error("DEPTH must be at least 2");
    end
    if (DATA_W > MERGE_W) begin : g_width_chk
        $error("entry wider than merge helper");
    end

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] ptr_q, ptr_n;
    logic              idle;

    logic              wr_ok, rd_ok;
    logic              wr_go, wr_bad, rd_go, hit;
    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] rd_word;

    logic                  arr_we;
    logic [ADDR_W-1:0]     arr_waddr;
    logic [NUM_FIELDS-1:0] arr_wmask;
    logic [DATA_W-1:0]     arr_wdata;
    logic [DATA_W-1:0]     arr_rdata;

    logic              v1, e1;
    logic [DATA_W-1:0] d1;

    assign idle = (state_q == IDLE);
    assign busy = ~idle;

    // Sweep state register; reset starts a fresh sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
        end
    end

    // Next sweep state: one entry zeroed per cycle until the last one.
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_n = CLEAR;
                    ptr_n   = '0;
                end
            end
            CLEAR: begin
                ptr_n = ptr_q + 1'b1;
                if (ptr_q == LAST_C) begin
                    state_n = IDLE;
                    ptr_n   = '0;
                end
            end
            default: begin
                state_n = CLEAR;
                ptr_n   = '0;
            end
        endcase
    end

    assign wr_ok  = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_ok  = ({1'b0, rd_addr} < DEPTH_C);
    assign wr_go  = idle & wr_en & wr_ok;
    assign wr_bad = idle & wr_en & ~wr_ok;
    assign rd_go  = idle & rd_en;
    assign hit    = wr_go & rd_ok & (wr_addr == rd_addr);

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_mask
        assign bit_mask[i*FIELD_W +: FIELD_W] = {FIELD_W{wr_mask[i]}};
    end

    // Array write port: the sweep owns it while busy.
    always_comb begin
        arr_we    = wr_go;
        arr_waddr = wr_addr;
        arr_wmask = wr_mask;
        arr_wdata = wr_data;
        if (busy) begin
            arr_we    = 1'b1;
            arr_waddr = ptr_q;
            arr_wmask = '1;
            arr_wdata = '0;
        end
    end

    register_level1_array #(
        .NUM_FIELDS (NUM_FIELDS),
        .FIELD_W    (FIELD_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wmask (arr_wmask),
        .wdata (arr_wdata),
        .raddr (rd_addr),
        .rdata (arr_rdata)
    );

    // Read word: zero when out of range, merged with a same-address write.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            if (hit) begin
                rd_word = DATA_W'(field_merge(MERGE_W'(arr_rdata),
                                              MERGE_W'(wr_data),
                                              MERGE_W'(bit_mask)));
            end else begin
                rd_word = arr_rdata;
            end
        end
    end

    // First read stage and write error pulse; data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            d1     <= '0;
            e1     <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            v1     <= rd_go;
            wr_err <= wr_bad;
            if (rd_go) begin
                d1 <= rd_word;
                e1 <= ~rd_ok;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              v2, e2;
        logic [DATA_W-1:0] d2;

        // Optional second read stage for timing relief.
        always_ff @(posedge clk) begin
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
                e2 <= 1'b0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    d2 <= d1;
                    e2 <= e1;
                end
            end
        end

        assign rd_valid = v2;
        assign rd_data  = d2;
        assign rd_err   = e2;
    end else begin : g_noreg
        assign rd_valid = v1;
        assign rd_data  = d1;
        assign rd_err   = e1;
    end

endmodule
